i2c_register_sequencer: RTL

Command-level sequencer that drives `i2c_controller` to perform sensor register-block reads for the thermal camera path. It accepts a 16-bit start register and a word count. It issues a write transaction carrying the register pointer, then a separate read transaction of 2×N bytes, and streams the result out as 16-bit big-endian words. It sits between the frame-capture logic and `i2c_controller`, in the same `i2c_clk` domain.

---
 rtl/i2c_register_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_register_sequencer.sv
// i2c_register_sequencer: reads a block of 16-bit sensor registers through
// i2c_controller (pointer write, then a 2*N byte read), streaming big-endian words.
// Ports:
//   clk, reset (sync, active-low)
//   cmd_valid/cmd_ready, cmd_register, cmd_word_count : command in
//   word_valid, word_data, word_last                   : word stream out
//   done, error                                        : completion pulses
//   i2c_* outputs : registered controller strobes
//   i2c_busy, i2c_byte_done, i2c_nack, i2c_received_data : controller status
module i2c_register_sequencer #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h33,
  parameter int COUNT_WIDTH = 10,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [15:0]            cmd_register,
  input  logic [COUNT_WIDTH-1:0] cmd_word_count,
  output logic                   word_valid,
  output logic [15:0]            word_data,
  output logic                   word_last,
  output logic                   done,
  output logic                   error,
  output logic                   i2c_start_transfer,
  output logic                   i2c_write_mode,
  output logic [7:0]             i2c_address,
  output logic [7:0]             i2c_transmit_data,
  output logic                   i2c_write_pending,
  output logic                   i2c_read_pending,
  input  logic                   i2c_busy,
  input  logic                   i2c_byte_done,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_received_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = COUNT_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_HI, W_LO, W_STOP,
    R_ADDR, R_DATA, R_STOP, ABORT
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic [15:0]     reg_q;
  logic [BW-1:0]   left_q;
  logic [7:0]      hi_q;
  logic [TW-1:0]   tmo_q;
  logic            wv_q;
  logic [15:0]     wdata_q;
  logic            wlast_q;
  logic            done_q;
  logic            err_q;
  logic            start_q;
  logic            wmode_q;
  logic [7:0]      addr_q;
  logic [7:0]      tx_q;
  logic            wpend_q;
  logic            rpend_q;

  logic tmo_hit;
  logic nack_st;
  logic wait_st;
  logic go_abort;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES));
  assign nack_st = state_q inside {W_ADDR, W_HI, W_LO, R_ADDR};
  assign wait_st = !(state_q inside {IDLE, ABORT});
  assign go_abort = (nack_st & i2c_byte_done & i2c_nack)
                  | (wait_st & tmo_hit);

  // Ready is gated by reset so it reads 0 while reset is held
  // and 1 as soon as it is released (state is already IDLE).
  assign cmd_ready          = ready_q & reset;
  assign word_valid         = wv_q;
  assign word_data          = wdata_q;
  assign word_last          = wlast_q;
  assign done               = done_q;
  assign error              = err_q;
  assign i2c_start_transfer = start_q;
  assign i2c_write_mode     = wmode_q;
  assign i2c_address        = addr_q;
  assign i2c_transmit_data  = tx_q;
  assign i2c_write_pending  = wpend_q;
  assign i2c_read_pending   = rpend_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      reg_q   <= '0;
      left_q  <= '0;
      hi_q    <= '0;
      tmo_q   <= '0;
      wv_q    <= 1'b0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      wmode_q <= 1'b0;
      addr_q  <= '0;
      tx_q    <= '0;
      wpend_q <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      wv_q    <= 1'b0;
      wlast_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= i2c_byte_done ? '0 : tmo_q + 1'b1;
      if (go_abort) begin
        state_q <= ABORT;
        start_q <= 1'b0;
        wpend_q <= 1'b0;
        rpend_q <= 1'b0;
        tmo_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            tmo_q <= '0;
            if (cmd_valid && ready_q) begin
              reg_q  <= cmd_register;
              left_q <= {cmd_word_count, 1'b0};
              if (cmd_word_count == '0) begin
                err_q <= 1'b1;
              end else begin
                state_q <= W_ADDR;
                ready_q <= 1'b0;
                start_q <= 1'b1;
                wmode_q <= 1'b1;
                addr_q  <= {DEVICE_ADDRESS, 1'b0};
                tx_q    <= cmd_register[15:8];
                wpend_q <= 1'b1;
                rpend_q <= 1'b0;
              end
            end
          end
          W_ADDR: if (i2c_byte_done) begin
            state_q <= W_HI;
            tx_q    <= reg_q[7:0];
            wpend_q <= 1'b0;
          end
          W_HI: if (i2c_byte_done) state_q <= W_LO;
          W_LO: if (i2c_byte_done) begin
            state_q <= W_STOP;
            start_q <= 1'b0;
          end
          W_STOP: if (!i2c_busy) begin
            state_q <= R_ADDR;
            start_q <= 1'b1;
            wmode_q <= 1'b0;
            addr_q  <= {DEVICE_ADDRESS, 1'b1};
            rpend_q <= (left_q > BW'(1));
            tmo_q   <= '0;
          end
          R_ADDR: if (i2c_byte_done) state_q <= R_DATA;
          R_DATA: if (i2c_byte_done) begin
            left_q  <= left_q - 1'b1;
            // ACK the next byte only if one more follows it
            rpend_q <= (left_q > BW'(2));
            // left_q is even on a high byte, odd on a low byte
            if (!left_q[0]) begin
              hi_q <= i2c_received_data;
            end else begin
              wv_q    <= 1'b1;
              wdata_q <= {hi_q, i2c_received_data};
              wlast_q <= (left_q == BW'(1));
            end
            if (left_q == BW'(1)) begin
              state_q <= R_STOP;
              start_q <= 1'b0;
            end
          end
          R_STOP: if (!i2c_busy) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            tmo_q   <= '0;
          end
          ABORT: if (!i2c_busy || tmo_hit) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            tmo_q   <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
